// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: single-clock camera pixel capture.
// pclk/vsync/href/camData are oversampled through a synchroniser chain. Bus
// bytes are assembled into pixels and tagged with X/Y and frame/line flags.
// Tagged pixels are buffered in a first-word-fall-through FIFO that feeds a
// valid/ready stream.
// Optional feature: define CAPTURE_DECIMATE_EN to keep only even-X/even-Y
// pixels. Those pixels are reported with half-resolution coordinates.
module ov7670_pixel_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int FIFO_DEPTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter bit VSYNC_POL     = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              pclk,
  input  logic                              vsync,
  input  logic                              href,
  input  logic [DATA_W-1:0]                 camData,
  input  logic                              clearErr,
  input  logic                              pixelReady,
  output logic                              pixelValid,
  output logic [DATA_W*BYTES_PER_PIX-1:0]   pixelData,
  output logic [$clog2(H_ACTIVE)-1:0]       pixelX,
  output logic [$clog2(V_ACTIVE)-1:0]       pixelY,
  output logic                              frameStart,
  output logic                              lineEnd,
  output logic                              frameDone,
  output logic                              overflow,
  output logic                              lineErr,
  output logic                              frameErr
);
  localparam int PW  = DATA_W * BYTES_PER_PIX;
  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  // Counters need one extra code so they can hold H_ACTIVE/V_ACTIVE itself.
  localparam int XCW = $clog2(H_ACTIVE + 1);
  localparam int YCW = $clog2(V_ACTIVE + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PHW = 2;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fs;
    logic          le;
  } pix_t;

  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_ACT, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0]             pclk_sr, vs_sr, href_sr;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] dat_sr;
  logic                               pclk_d, href_d;
  logic                               pclk_s, vs_s, href_s;
  logic [DATA_W-1:0]                  dat_s;

  // Synchroniser chains. The data chain has the same length as the control
  // chains, so a byte stays aligned with its own pclk edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_sr <= '0;
      vs_sr   <= '0;
      href_sr <= '0;
      dat_sr  <= '0;
      pclk_d  <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      pclk_sr <= {pclk_sr[SYNC_STAGES-2:0], pclk};
      vs_sr   <= {vs_sr[SYNC_STAGES-2:0], vsync};
      href_sr <= {href_sr[SYNC_STAGES-2:0], href};
      dat_sr  <= {dat_sr[SYNC_STAGES-2:0], camData};
      pclk_d  <= pclk_s;
      href_d  <= href_s;
    end
  end

  assign pclk_s = pclk_sr[SYNC_STAGES-1];
  assign vs_s   = vs_sr[SYNC_STAGES-1];
  assign href_s = href_sr[SYNC_STAGES-1];
  assign dat_s  = dat_sr[SYNC_STAGES-1];

  state_t         state;
  logic [XCW-1:0] x_cnt;
  logic [YCW-1:0] y_cnt;
  logic [PHW-1:0] phase;
  logic [PW-1:0]  shreg, sh_next;
  logic           st_vld;
  pix_t           st_pix;
  logic           vs_blank, in_act, href_fall, byte_ok, pix_last;
  logic           x_over, y_over, keep, le_hit;
  logic [XW-1:0]  px;
  logic [YW-1:0]  py;
  logic           line_evt, frame_evt;

  assign vs_blank  = (vs_s == VSYNC_POL);
  assign in_act    = (state == ACTIVE) & ~vs_blank;
  assign href_fall = in_act & href_d & ~href_s;
  assign byte_ok   = in_act & pclk_s & ~pclk_d & href_s;
  assign pix_last  = byte_ok & (phase == PHW'(BYTES_PER_PIX - 1));
  assign sh_next   = (shreg << DATA_W) | PW'(dat_s);
  assign x_over    = (x_cnt >= XCW'(H_ACTIVE));
  assign y_over    = (y_cnt >= YCW'(V_ACTIVE));
`ifdef CAPTURE_DECIMATE_EN
  assign keep   = ~x_over & ~y_over & ~x_cnt[0] & ~y_cnt[0];
  assign px     = XW'(x_cnt >> 1);
  assign py     = YW'(y_cnt >> 1);
  assign le_hit = (x_cnt == XCW'(H_ACTIVE - 2));
`else
  assign keep   = ~x_over & ~y_over;
  assign px     = XW'(x_cnt);
  assign py     = YW'(y_cnt);
  assign le_hit = (x_cnt == XCW'(H_ACTIVE - 1));
`endif

  assign line_evt  = (pix_last & x_over) | (href_fall & (x_cnt != XCW'(H_ACTIVE)));
  assign frame_evt = (pix_last & y_over) |
                     ((state == ACTIVE) & vs_blank & (y_cnt != YCW'(V_ACTIVE)));

  // Frame FSM, byte assembly and X/Y tracking. A completed pixel is staged
  // for one cycle before it is pushed into the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      phase     <= '0;
      shreg     <= '0;
      st_vld    <= 1'b0;
      st_pix    <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      st_vld    <= 1'b0;
      case (state)
        IDLE:     if (enable) state <= WAIT_VS;
        WAIT_VS:  if (vs_blank) state <= WAIT_ACT;
        WAIT_ACT: if (!vs_blank) begin
          state <= ACTIVE;
          x_cnt <= '0;
          y_cnt <= '0;
          phase <= '0;
        end
        ACTIVE: begin
          if (vs_blank) begin
            frameDone <= 1'b1;
            state     <= enable ? WAIT_ACT : IDLE;
          end else if (href_fall) begin
            phase <= '0;
            x_cnt <= '0;
            if (!y_over) y_cnt <= y_cnt + YCW'(1);
          end else if (pix_last) begin
            phase  <= '0;
            st_vld <= keep;
            st_pix <= '{data: sh_next, x: px, y: py,
                        fs: (x_cnt == '0) && (y_cnt == '0), le: le_hit};
            if (!x_over) x_cnt <= x_cnt + XCW'(1);
          end else if (byte_ok) begin
            phase <= phase + PHW'(1);
            shreg <= sh_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pix_t        mem [FIFO_DEPTH];
  pix_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, push, ovf_evt;

  assign pixelValid = (wr_ptr != rd_ptr);
  assign full       = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));
  assign pop        = pixelValid & pixelReady;
  // On a full FIFO, a simultaneous pop frees the slot for the incoming pixel.
  assign push       = st_vld & (~full | pop);
  assign ovf_evt    = st_vld & full & ~pop;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign {pixelData, pixelX, pixelY, frameStart, lineEnd} = pixelValid ? head : '0;

  // FIFO pointers. The storage itself needs no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= st_pix;
  end

  // Sticky error flags. A new error outranks clearErr in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      lineErr  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      overflow <= (overflow & ~clearErr) | ovf_evt;
      lineErr  <= (lineErr  & ~clearErr) | line_evt;
      frameErr <= (frameErr & ~clearErr) | frame_evt;
    end
  end
endmodule
